sync_debounce: RTL
==================

// Module: sync_debounce
// PURPOSE
//   Multi-channel CDC input conditioner: parametrised-depth flop synchroniser
//   per bit, then a per-channel stability (debounce) filter and registered
//   rise/fall edge pulses. Sits at the boundary for asynchronous level inputs
//   (buttons, status lines, slow strobes) and feeds control FSMs in the clk domain.
// PARAMETERS
//   WIDTH          4   number of independent channels (>=1)
//   STAGES         2   synchroniser flop depth (>=2)
//   FILTER_CYCLES  4   consecutive cycles a new level must persist before out_filt follows (>=1)
//   RST_VAL        '0  WIDTH-bit reset value of all sync stages and out_filt
// PORTS
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous active-low reset
//   in           in   WIDTH  asynchronous level inputs
//   filt_bypass  in   1      1: filter threshold forced to 1 (quasi-static, clk domain)
//   out_synced   out  WIDTH  raw synchronised value (last sync stage)
//   out_filt     out  WIDTH  debounced level
//   rise_pulse   out  WIDTH  1-cycle pulse when out_filt[i] goes 0->1
//   fall_pulse   out  WIDTH  1-cycle pulse when out_filt[i] goes 1->0
// BEHAVIOUR
// - Reset (rst_n=0, async): all sync stages and out_filt = RST_VAL; out_synced = RST_VAL;
//   counters = 0; rise_pulse = fall_pulse = 0. No pulses generated on reset release.
// - Sync chain: STAGES flops per bit, all clocked by clk. Stage 1 samples in.
//   out_synced = last stage, registered. in change set up before edge e0 appears on
//   out_synced after edge e(STAGES-1), i.e. STAGES edges of latency.
//   No logic between sync stages.
// - Filter, per channel i, evaluated every posedge. Counter cnt_i is
//   $clog2(FILTER_CYCLES+1) bits; TH = filt_bypass ? 1 : FILTER_CYCLES.
//     out_synced[i] == out_filt[i]     : cnt_i <= 0.
//     differs, cnt_i == TH-1           : out_filt[i] <= out_synced[i]; cnt_i <= 0 (flip).
//     differs, cnt_i <  TH-1           : cnt_i <= cnt_i + 1.
//   Result: out_filt follows a level held on out_synced for TH consecutive cycles,
//   TH edges after out_synced changes. Total in->out_filt latency is STAGES+TH edges.
//   Any return to the old level before the threshold clears cnt_i (glitch rejected).
// - Edge pulses: registered at the same edge as the flip.
//   rise_pulse[i] <= flip_i & out_synced[i]; fall_pulse[i] <= flip_i & ~out_synced[i].
//   Each pulse is high exactly 1 cycle, coincident with the first cycle of the new
//   out_filt level. rise and fall are never both high on one channel.
// - Channels are fully independent: simultaneous changes on several bits each
//   follow the rules above in parallel, with no cross-channel ordering.
// - filt_bypass toggled mid-count: new TH applies from the next edge. If
//   cnt_i >= TH-1 and the level still differs, flip at that edge. Counter never
//   overflows.
// - Reset asserted mid-count or mid-pulse: immediate return to reset values.
//   Pending counts are discarded.
// TESTING (WIDTH=4, STAGES=2, FILTER_CYCLES=4, RST_VAL=0 unless noted)
// 1 Reset with in=4'hF -> all outputs 0. Release rst_n -> out_synced=F after 2 edges,
//   out_filt=F 4 edges later, rise_pulse=F for exactly 1 cycle.
// 2 in[0] 0->1 held -> out_synced[0] at edge 2, out_filt[0] and rise_pulse[0] at edge 6.
//   Pulse drops at edge 7. Then 1->0 -> fall_pulse[0] at edge 6 after the change.
// 3 in[1] high for 3 cycles then low -> out_synced[1] pulses 3 cycles; out_filt[1]
//   stays 0; no pulses. Held high for 4 cycles -> out_filt[1] rises.
// 4 in[2] rises, in[3] falls (from 1) on the same cycle -> rise_pulse[2] and
//   fall_pulse[3] in the same cycle, edge 6.
// 5 filt_bypass=1, in[0] toggles -> out_filt[0] follows at edge 3 (2+1), pulse per toggle.
// 6 rst_n asserted with cnt_i=2 -> outputs 0 asynchronously. After release, a held level
//   needs the full 2+4 edges again. Repeat with STAGES=3, RST_VAL=4'hA.

Source files
------------

// File: rtl/sync_debounce.sv
// ----------------------------------------------------------------------------
// sync_debounce
//   Multi-channel input conditioner for asynchronous level inputs.
//   Each bit passes through a STAGES-deep flop synchroniser. A per-channel
//   stability filter then updates out_filt only after the synchronised level
//   has differed from it for TH consecutive cycles. Each filter flip also
//   produces a registered one-cycle rise or fall pulse.
//
// Parameters
//   WIDTH          number of independent channels
//   STAGES         synchroniser depth (>= 2)
//   FILTER_CYCLES  cycles a new level must persist before out_filt follows
//   RST_VAL        reset value of every sync stage and of out_filt
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   in           asynchronous level inputs
//   filt_bypass  1: filter threshold forced to 1 (quasi-static, clk domain)
//   out_synced   last synchroniser stage
//   out_filt     debounced level
//   rise_pulse   one-cycle pulse on an out_filt 0->1 transition
//   fall_pulse   one-cycle pulse on an out_filt 1->0 transition
// ----------------------------------------------------------------------------
module sync_debounce #(
   parameter int unsigned      WIDTH         = 4,
   parameter int unsigned      STAGES        = 2,
   parameter int unsigned      FILTER_CYCLES = 4,
   parameter logic [WIDTH-1:0] RST_VAL       = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in,
   input  logic             filt_bypass,
   output logic [WIDTH-1:0] out_synced,
   output logic [WIDTH-1:0] out_filt,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);

   localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);

   logic [WIDTH-1:0] sync_q [STAGES];
   logic [CW-1:0]    cnt_q  [WIDTH];
   logic [CW-1:0]    cnt_d  [WIDTH];
   logic [WIDTH-1:0] filt_q, filt_d;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] flip;
   logic [CW-1:0]    th_m1;

   // Plain flop chain; nothing may sit between stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            sync_q[s] <= RST_VAL;
         end
      end else begin
         sync_q[0] <= in;
         for (int unsigned s = 1; s < STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign out_synced = sync_q[STAGES-1];

   assign th_m1 = filt_bypass ? '0 : CW'(FILTER_CYCLES - 1);

   // Flip on >= rather than == so that lowering the threshold mid-count
   // (bypass enabled) flips at once; the counter then never passes th_m1.
   always_comb begin
      flip   = '0;
      filt_d = filt_q;
      rise_d = '0;
      fall_d = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (out_synced[i] != filt_q[i]) begin
            if (cnt_q[i] >= th_m1) begin
               flip[i]   = 1'b1;
               filt_d[i] = out_synced[i];
               cnt_d[i]  = '0;
            end else begin
               cnt_d[i]  = cnt_q[i] + CW'(1);
            end
         end
         rise_d[i] = flip[i] &  out_synced[i];
         fall_d[i] = flip[i] & ~out_synced[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= RST_VAL;
         rise_q <= '0;
         fall_q <= '0;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         filt_q <= filt_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign out_filt   = filt_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;

endmodule
